fb_write_scheduler: RTL and testbench
=====================================

# fb_write_scheduler

Schedules all frame-buffer writes from the ray-marcher cores and owns double-buffer bank selection. Up to NUM_CORES cores offer finished pixels; the block grants one per cycle round-robin onto the single BRAM write port. Writes are steered into the back bank. On the first display vsync after a full frame has been written, the banks swap and all cores are told to start the next frame. It sits between the cores and the frame-buffer BRAM, in the VGA pixel clock domain.

## Interface
- NUM_CORES, 4: number of requesting cores (2..8)
- ADDR_BITS, `ADDR_BITS: pixel address width within one bank
- PIXEL_COUNT, `DISPLAY_WIDTH*`DISPLAY_HEIGHT: writes that complete one frame
- clk_in  input  1  pixel clock (same clock as vga_display)
- rst_n_in  input  1  asynchronous, active-low reset
- core_valid_in  input  NUM_CORES  core i has a pixel pending
- core_addr_in  input  NUM_CORES*ADDR_BITS  packed pixel addresses; core i at [i*ADDR_BITS +: ADDR_BITS]
- core_data_in  input  NUM_CORES*4  packed 4-bit grayscale; core i at [i*4 +: 4]
- core_ready_out  output  NUM_CORES  one-hot grant, combinational; transfer when valid&ready
- vsync_in  input  1  display vsync, already in clk_in domain, active high
- write_en_out  output  1  BRAM write strobe
- write_addr_out  output  ADDR_BITS+1  {back bank, pixel address}
- write_data_out  output  4  pixel value
- display_bank_out  output  1  bank the display reads (MSB of display read address)
- frame_start_out  output  1  one-cycle pulse: cores begin a new frame
- frame_count_out  output  8  completed swaps, wraps at 255

## Operation
- States: IDLE, RENDER, WAIT_SWAP.
- IDLE: entered on reset. Next cycle, pulse frame_start_out and go to RENDER.
- RENDER:
  - core_ready_out = one-hot of the first core with valid set, searching from rr_ptr upward with wrap. It is zero if no core is valid.
  - On a transfer from core i: rr_ptr <= i+1 mod NUM_CORES, and pix_cnt increments.
  - When an accepted transfer makes pix_cnt == PIXEL_COUNT, go to WAIT_SWAP.
- WAIT_SWAP:
  - core_ready_out = 0.
  - On a vsync_in rising edge (vsync_in & ~vsync_q): display_bank_out toggles, pix_cnt <= 0, frame_count_out increments, frame_start_out pulses, go to RENDER.
- Back bank = ~display_bank_out. write_addr_out MSB uses the back bank value from the cycle of acceptance.
- pix_cnt is sized $clog2(PIXEL_COUNT+1) and never exceeds PIXEL_COUNT.
- The block does not check for duplicate addresses. Cores own address uniqueness.
- vsync rising edges during IDLE or RENDER are ignored; vsync_q still tracks vsync_in.

## Timing
- Reset values (all asynchronous): write_en_out 0, write_addr_out 0, write_data_out 0, display_bank_out 0, frame_start_out 0, frame_count_out 0, rr_ptr 0, pix_cnt 0, vsync_q 0, state IDLE. core_ready_out is 0 while in IDLE.
- Write latency: 1 cycle. A transfer at edge N drives write_en_out/addr/data during cycle N+1. write_en_out is 0 in any cycle with no transfer.
- Throughput: 1 pixel per cycle in RENDER.
- The final pixel's write is issued the cycle after acceptance, which is already in WAIT_SWAP, so the final write always lands in the old back bank.
- Swap occurs at the edge where the rising edge is detected. display_bank_out and frame_start_out change at that edge; the first new-frame transfer is possible on the following cycle.
- Last pixel accepted in the same cycle as a vsync rising edge: no swap; wait for the next vsync rise.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is discarded and bank 0 is displayed.

## Test plan
- Reset, then release with no valids -> frame_start_out high exactly one cycle after release; core_ready_out 0; write_en_out 0; display_bank_out 0.
- All 4 cores valid continuously -> grants cycle 0,1,2,3,0…. Each write appears 1 cycle later with addr MSB 1 and matching data.
- Only cores 1 and 3 valid -> grants alternate 1,3,1,3; cores 0 and 2 are never granted.
- PIXEL_COUNT=8, write 8 pixels, then vsync rises 5 cycles later -> ready is 0 during the wait; on the rise display_bank_out becomes 1, frame_count_out becomes 1, frame_start_out pulses; the next writes carry MSB 0.
- Vsync rises mid-frame, and again in the same cycle the last pixel is accepted -> no swap on either edge; the swap happens only on the next rise.
- Assert rst_n_in low in the middle of frame 2 -> all outputs return to reset values immediately; after release the sequence restarts with frame_start_out pulsed.

Source files
------------

// File: rtl/fb_write_scheduler_if.sv
// Core-to-scheduler pixel handshake plus the scheduler's BRAM write port.
`timescale 1ns/1ps
interface fb_write_scheduler_if #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_BITS = 15,
  parameter int DATA_W    = 4
);
  logic [NUM_CORES-1:0]           core_valid_in;
  logic [NUM_CORES*ADDR_BITS-1:0] core_addr_in;
  logic [NUM_CORES*DATA_W-1:0]    core_data_in;
  logic [NUM_CORES-1:0]           core_ready_out;
  logic                           write_en_out;
  logic [ADDR_BITS:0]             write_addr_out;
  logic [DATA_W-1:0]              write_data_out;

  modport slave (
    input  core_valid_in, core_addr_in, core_data_in,
    output core_ready_out, write_en_out, write_addr_out, write_data_out
  );

  modport master (
    output core_valid_in, core_addr_in, core_data_in,
    input  core_ready_out, write_en_out, write_addr_out, write_data_out
  );
endinterface

// File: rtl/fb_write_scheduler.sv
// Round-robin frame-buffer write arbiter with vsync-synchronised double-buffer swap.
`timescale 1ns/1ps
module fb_write_scheduler #(
  parameter int NUM_CORES   = 4,
  parameter int ADDR_BITS   = 15,
  parameter int PIXEL_COUNT = 19200,
  parameter int DATA_W      = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  fb_write_scheduler_if.slave   bus,
  input  logic                  vsync_in,
  output logic                  display_bank_out,
  output logic                  frame_start_out,
  output logic [7:0]            frame_count_out
);
  localparam int IDX_W = $clog2(NUM_CORES);
  localparam int CNT_W = $clog2(PIXEL_COUNT + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RENDER    = 2'd1;
  localparam logic [1:0] WAIT_SWAP = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     pix_cnt_q, pix_cnt_d;
  logic                 bank_q, bank_d;
  logic                 fstart_q, fstart_d;
  logic [7:0]           fcnt_q, fcnt_d;
  logic                 vsync_q;
  logic                 vsync_rise;

  logic [NUM_CORES-1:0] gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic [IDX_W-1:0]     cand;
  logic                 found;
  logic                 xfer;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_W-1:0]    sel_data;

  logic                 vld_p1;
  logic [ADDR_BITS:0]   wr_addr_p1;
  logic [DATA_W-1:0]    wr_data_p1;

  assign vsync_rise = vsync_in & ~vsync_q;

  // Descending scan so the last hit (smallest offset from rr_ptr) wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (state_q == RENDER) begin
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
        cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_CORES);
        if (bus.core_valid_in[cand]) begin
          found   = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  assign gnt      = found ? (NUM_CORES'(1) << gnt_idx) : '0;
  assign xfer     = found;
  assign sel_addr = bus.core_addr_in[gnt_idx*ADDR_BITS +: ADDR_BITS];
  assign sel_data = bus.core_data_in[gnt_idx*DATA_W +: DATA_W];

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    pix_cnt_d = pix_cnt_q;
    bank_d    = bank_q;
    fstart_d  = 1'b0;
    fcnt_d    = fcnt_q;
    case (state_q)
      IDLE: begin
        fstart_d = 1'b1;
        state_d  = RENDER;
      end
      RENDER: begin
        if (xfer) begin
          rr_ptr_d  = (gnt_idx == IDX_W'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;
          pix_cnt_d = pix_cnt_q + CNT_W'(1);
          if (pix_cnt_d == CNT_W'(PIXEL_COUNT)) state_d = WAIT_SWAP;
        end
      end
      WAIT_SWAP: begin
        // A rise coinciding with the last accepted pixel is seen in RENDER and ignored.
        if (vsync_rise) begin
          bank_d    = ~bank_q;
          pix_cnt_d = '0;
          fcnt_d    = fcnt_q + 8'd1;
          fstart_d  = 1'b1;
          state_d   = RENDER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      pix_cnt_q <= '0;
      bank_q    <= 1'b0;
      fstart_q  <= 1'b0;
      fcnt_q    <= '0;
      vsync_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      pix_cnt_q <= pix_cnt_d;
      bank_q    <= bank_d;
      fstart_q  <= fstart_d;
      fcnt_q    <= fcnt_d;
      vsync_q   <= vsync_in;
    end
  end

  // Stage p1: accepted pixel registered onto the BRAM port, tagged with the current back bank.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_p1     <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      vld_p1 <= xfer;
      if (xfer) begin
        wr_addr_p1 <= {~bank_q, sel_addr};
        wr_data_p1 <= sel_data;
      end
    end
  end

  assign bus.core_ready_out = gnt;
  assign bus.write_en_out   = vld_p1;
  assign bus.write_addr_out = wr_addr_p1;
  assign bus.write_data_out = wr_data_p1;
  assign display_bank_out   = bank_q;
  assign frame_start_out    = fstart_q;
  assign frame_count_out    = fcnt_q;
endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler: arbitration order, write latency, bank swap and reset.
`timescale 1ns/1ps
module tb_fb_write_scheduler;
  localparam int NC = 4;
  localparam int AB = 4;
  localparam int PC = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vsync;
  logic       bank;
  logic       fstart;
  logic [7:0] fcnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] ADDR_TAB [NC] = '{4'h2, 4'h5, 4'h9, 4'hC};
  logic [3:0] DATA_TAB [NC] = '{4'h3, 4'hA, 4'h7, 4'hD};

  fb_write_scheduler_if #(.NUM_CORES(NC), .ADDR_BITS(AB), .DATA_W(4)) bus ();

  fb_write_scheduler #(
    .NUM_CORES(NC), .ADDR_BITS(AB), .PIXEL_COUNT(PC), .DATA_W(4)
  ) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .bus              (bus),
    .vsync_in         (vsync),
    .display_bank_out (bank),
    .frame_start_out  (fstart),
    .frame_count_out  (fcnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge with valids already set: expects core c granted now and its write next cycle.
  task automatic step_grant(input int c, input logic msb);
    #1;
    check_eq("ready", 32'(bus.core_ready_out), 32'(1 << c));
    @(negedge clk);
    check_eq("wen",   32'(bus.write_en_out), 32'd1);
    check_eq("waddr", 32'(bus.write_addr_out), 32'({msb, ADDR_TAB[c]}));
    check_eq("wdata", 32'(bus.write_data_out), 32'(DATA_TAB[c]));
  endtask

  task automatic check_reset_vals();
    check_eq("rst_wen",   32'(bus.write_en_out), 32'd0);
    check_eq("rst_waddr", 32'(bus.write_addr_out), 32'd0);
    check_eq("rst_wdata", 32'(bus.write_data_out), 32'd0);
    check_eq("rst_bank",  32'(bank), 32'd0);
    check_eq("rst_fstart",32'(fstart), 32'd0);
    check_eq("rst_fcnt",  32'(fcnt), 32'd0);
    check_eq("rst_ready", 32'(bus.core_ready_out), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    vsync = 1'b0;
    bus.core_valid_in = '0;
    for (int i = 0; i < NC; i++) begin
      bus.core_addr_in[i*AB +: AB] = ADDR_TAB[i];
      bus.core_data_in[i*4 +: 4]   = DATA_TAB[i];
    end

    repeat (2) @(negedge clk);
    bus.core_valid_in = 4'hF;
    #1;
    check_reset_vals();
    bus.core_valid_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("start_pulse", 32'(fstart), 32'd1);
    check_eq("start_ready", 32'(bus.core_ready_out), 32'd0);
    check_eq("start_wen",   32'(bus.write_en_out), 32'd0);
    check_eq("start_bank",  32'(bank), 32'd0);
    @(negedge clk);
    check_eq("start_pulse_end", 32'(fstart), 32'd0);

    // Frame 1: all cores valid, then only cores 1 and 3.
    bus.core_valid_in = 4'hF;
    for (int c = 0; c < NC; c++) step_grant(c, 1'b1);
    bus.core_valid_in = 4'b1010;
    step_grant(1, 1'b1);
    step_grant(3, 1'b1);
    step_grant(1, 1'b1);
    step_grant(3, 1'b1);
    check_eq("wait_ready", 32'(bus.core_ready_out), 32'd0);
    check_eq("wait_bank",  32'(bank), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check_eq("wait_ready", 32'(bus.core_ready_out), 32'd0);
      check_eq("wait_wen",   32'(bus.write_en_out), 32'd0);
      check_eq("wait_fcnt",  32'(fcnt), 32'd0);
    end
    vsync = 1'b1;
    @(negedge clk);
    check_eq("swap1_bank",   32'(bank), 32'd1);
    check_eq("swap1_fcnt",   32'(fcnt), 32'd1);
    check_eq("swap1_fstart", 32'(fstart), 32'd1);

    // Frame 2: vsync rises mid-frame and again on the last acceptance.
    bus.core_valid_in = 4'hF;
    vsync = 1'b0;
    step_grant(0, 1'b0);
    check_eq("f2_fstart", 32'(fstart), 32'd0);
    vsync = 1'b1;
    step_grant(1, 1'b0);
    check_eq("mid_bank", 32'(bank), 32'd1);
    check_eq("mid_fcnt", 32'(fcnt), 32'd1);
    step_grant(2, 1'b0);
    vsync = 1'b0;
    step_grant(3, 1'b0);
    step_grant(0, 1'b0);
    step_grant(1, 1'b0);
    step_grant(2, 1'b0);
    vsync = 1'b1;
    step_grant(3, 1'b0);
    check_eq("last_bank",   32'(bank), 32'd1);
    check_eq("last_fcnt",   32'(fcnt), 32'd1);
    check_eq("last_ready",  32'(bus.core_ready_out), 32'd0);
    check_eq("last_fstart", 32'(fstart), 32'd0);
    @(negedge clk);
    check_eq("hold_bank", 32'(bank), 32'd1);
    vsync = 1'b0;
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    check_eq("swap2_bank",   32'(bank), 32'd0);
    check_eq("swap2_fcnt",   32'(fcnt), 32'd2);
    check_eq("swap2_fstart", 32'(fstart), 32'd1);

    // Frame 3: reset mid-frame.
    vsync = 1'b0;
    step_grant(0, 1'b1);
    step_grant(1, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("restart_fstart", 32'(fstart), 32'd1);
    check_eq("restart_bank",   32'(bank), 32'd0);
    check_eq("restart_fcnt",   32'(fcnt), 32'd0);
    step_grant(0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
